// File: rtl/des_key_schedule.sv
// DES subkey generator: latches a key on load, applies PC-1, and on each
// step presents one registered 48-bit PC-2 subkey (K1..K16 when encrypting,
// K16..K1 when decrypting) for the round datapath to use in the next cycle.
module des_key_schedule #(
   parameter int NUM_ROUNDS = 16
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [63:0] key_in,
   input  logic        decrypt,
   input  logic        load,
   input  logic        step,
   output logic [47:0] subkey,
   output logic        subkey_valid,
   output logic [3:0]  subkey_round,
   output logic        busy,
   output logic        done
);

   // Bit lists use FIPS numbering: entry value n refers to bit n, bit 1 = MSB.
   localparam int PC1 [56] = '{
      57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
      10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
      63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
      14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
   };

   localparam int PC2 [48] = '{
      14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
      23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
      41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
      44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
   };

   localparam logic [4:0] ROUNDS_TOTAL = 5'(NUM_ROUNDS);
   localparam logic [4:0] LAST_ROUND   = 5'(NUM_ROUNDS - 1);

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   state_t      state_reg, state_next;
   logic [27:0] c_reg, c_next;
   logic [27:0] d_reg, d_next;
   logic [4:0]  cnt_reg, cnt_next;
   logic        dir_reg, dir_next;
   logic [47:0] subkey_reg, subkey_next;
   logic        valid_reg, valid_next;
   logic [3:0]  round_reg, round_next;
   logic        done_reg, done_next;

   logic [55:0] pc1_cd;
   logic [27:0] rot_c, rot_d;
   logic [55:0] rot_cd;
   logic [47:0] pc2_key;

   // Parity bits of the key and the eight C/D bits PC-2 drops are
   // intentionally not used; folding them here keeps lint quiet.
   logic unused_bits;
   assign unused_bits = ^{key_in[56], key_in[48], key_in[40], key_in[32],
                          key_in[24], key_in[16], key_in[8],  key_in[0],
                          rot_cd};

   // Left rotation amount for encrypt round i.
   function automatic logic [1:0] lshift_amt(input logic [3:0] i);
      case (i)
         4'd0, 4'd1, 4'd8, 4'd15: lshift_amt = 2'd1;
         default:                 lshift_amt = 2'd2;
      endcase
   endfunction

   // Right rotation amount for decrypt round i; round 0 is unrotated (K16).
   function automatic logic [1:0] rshift_amt(input logic [3:0] i);
      case (i)
         4'd0:                  rshift_amt = 2'd0;
         4'd1, 4'd8, 4'd15:     rshift_amt = 2'd1;
         default:               rshift_amt = 2'd2;
      endcase
   endfunction

   function automatic logic [27:0] rotl(input logic [27:0] v, input logic [1:0] n);
      case (n)
         2'd1:    rotl = {v[26:0], v[27]};
         2'd2:    rotl = {v[25:0], v[27:26]};
         default: rotl = v;
      endcase
   endfunction

   function automatic logic [27:0] rotr(input logic [27:0] v, input logic [1:0] n);
      case (n)
         2'd1:    rotr = {v[0], v[27:1]};
         2'd2:    rotr = {v[1:0], v[27:2]};
         default: rotr = v;
      endcase
   endfunction

   genvar gi;

   // PC-1 is pure wiring from the key onto the 56-bit C||D vector.
   generate
      for (gi = 0; gi < 56; gi++) begin : g_pc1
         assign pc1_cd[55-gi] = key_in[64-PC1[gi]];
      end
   endgenerate

   // PC-2 is pure wiring from the rotated C||D onto the subkey.
   generate
      for (gi = 0; gi < 48; gi++) begin : g_pc2
         assign pc2_key[47-gi] = rot_cd[56-PC2[gi]];
      end
   endgenerate

   // Rotate C and D for the round selected by cnt in the latched direction.
   always_comb begin
      rot_c = c_reg;
      rot_d = d_reg;
      if (dir_reg) begin
         rot_c = rotr(c_reg, rshift_amt(cnt_reg[3:0]));
         rot_d = rotr(d_reg, rshift_amt(cnt_reg[3:0]));
      end else begin
         rot_c = rotl(c_reg, lshift_amt(cnt_reg[3:0]));
         rot_d = rotl(d_reg, lshift_amt(cnt_reg[3:0]));
      end
   end

   assign rot_cd = {rot_c, rot_d};

   // Next-state and output logic; load always takes priority over step.
   always_comb begin
      state_next  = state_reg;
      c_next      = c_reg;
      d_next      = d_reg;
      cnt_next    = cnt_reg;
      dir_next    = dir_reg;
      subkey_next = subkey_reg;
      round_next  = round_reg;
      valid_next  = 1'b0;
      done_next   = 1'b0;

      if (load) begin
         c_next     = pc1_cd[55:28];
         d_next     = pc1_cd[27:0];
         dir_next   = decrypt;
         cnt_next   = 5'd0;
         state_next = RUN;
      end else if (state_reg == RUN && step && cnt_reg < ROUNDS_TOTAL) begin
         c_next      = rot_c;
         d_next      = rot_d;
         subkey_next = pc2_key;
         round_next  = cnt_reg[3:0];
         valid_next  = 1'b1;
         cnt_next    = cnt_reg + 5'd1;
         if (cnt_reg == LAST_ROUND) begin
            done_next  = 1'b1;
            state_next = IDLE;
         end
      end
   end

   // State and output registers, cleared asynchronously at any time.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_reg  <= IDLE;
         c_reg      <= '0;
         d_reg      <= '0;
         cnt_reg    <= '0;
         dir_reg    <= 1'b0;
         subkey_reg <= '0;
         valid_reg  <= 1'b0;
         round_reg  <= '0;
         done_reg   <= 1'b0;
      end else begin
         state_reg  <= state_next;
         c_reg      <= c_next;
         d_reg      <= d_next;
         cnt_reg    <= cnt_next;
         dir_reg    <= dir_next;
         subkey_reg <= subkey_next;
         valid_reg  <= valid_next;
         round_reg  <= round_next;
         done_reg   <= done_next;
      end
   end

   assign subkey       = subkey_reg;
   assign subkey_valid = valid_reg;
   assign subkey_round = round_reg;
   assign busy         = (state_reg == RUN);
   assign done         = done_reg;

endmodule

// File: tb/tb_des_key_schedule.sv
// Self-checking bench for des_key_schedule: golden FIPS vectors, a
// bit-serial software schedule model, and a scoreboard of expected pulses.
module tb_des_key_schedule;

   logic        clk;
   logic        reset_n;
   logic [63:0] key_in;
   logic        decrypt;
   logic        load;
   logic        step;
   logic [47:0] subkey;
   logic        subkey_valid;
   logic [3:0]  subkey_round;
   logic        busy;
   logic        done;

   des_key_schedule #(.NUM_ROUNDS(16)) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .key_in       (key_in),
      .decrypt      (decrypt),
      .load         (load),
      .step         (step),
      .subkey       (subkey),
      .subkey_valid (subkey_valid),
      .subkey_round (subkey_round),
      .busy         (busy),
      .done         (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   localparam int PC1_T [56] = '{
      57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
      10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
      63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
      14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
   };
   localparam int PC2_T [48] = '{
      14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
      23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
      41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
      44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
   };
   localparam int SH_T [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

   localparam logic [63:0] KEY_A = 64'h133457799BBCDFF1;
   localparam logic [63:0] KEY_B = 64'h0E329232EA6D0D73;

   typedef struct {
      logic [3:0]  round;
      logic [47:0] subkey;
   } gold_t;

   typedef struct {
      logic [47:0] subkey;
      logic [3:0]  round;
      logic        done;
      int          due;
   } exp_t;

   gold_t       gold [16];
   logic [47:0] mdl_keys [16];
   logic [47:0] exp_keys [16];
   int          exp_cnt;
   bit          exp_armed;
   exp_t        sb_q [$];
   exp_t        mon_e;
   int          cyc = 0;
   int          checks = 0;
   int          failures = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h (cycle %0d)", nm, act, req, cyc);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Straightforward schedule: PC-1, then repeated single-bit left rotations.
   task automatic model_keys_for(input logic [63:0] k);
      logic [55:0] cd;
      logic [27:0] c, d;
      logic [47:0] kk;
      for (int i = 0; i < 56; i++) cd[55-i] = k[64-PC1_T[i]];
      c = cd[55:28];
      d = cd[27:0];
      for (int r = 0; r < 16; r++) begin
         for (int s = 0; s < SH_T[r]; s++) begin
            c = {c[26:0], c[27]};
            d = {d[26:0], d[27]};
         end
         cd = {c, d};
         for (int j = 0; j < 48; j++) kk[47-j] = cd[56-PC2_T[j]];
         mdl_keys[r] = kk;
      end
   endtask

   task automatic arm(input logic [63:0] k, input logic dec, input bit use_gold);
      if (!use_gold) model_keys_for(k);
      for (int i = 0; i < 16; i++) begin
         if (dec) exp_keys[15-i] = use_gold ? gold[i].subkey : mdl_keys[i];
         else     exp_keys[i]    = use_gold ? gold[i].subkey : mdl_keys[i];
      end
      exp_cnt   = 0;
      exp_armed = 1'b1;
   endtask

   task automatic do_load(input logic [63:0] k, input logic dec, input logic [63:0] mk, input bit use_gold);
      key_in  = k;
      decrypt = dec;
      load    = 1'b1;
      arm(mk, dec, use_gold);
      tick();
      load = 1'b0;
   endtask

   task automatic step_once();
      exp_t e;
      if (exp_armed) begin
         e.subkey = exp_keys[exp_cnt];
         e.round  = 4'(exp_cnt);
         e.done   = (exp_cnt == 15);
         e.due    = cyc + 1;
         sb_q.push_back(e);
         exp_cnt++;
         if (exp_cnt == 16) exp_armed = 1'b0;
      end
      step = 1'b1;
      tick();
      step = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while (sb_q.size() != 0 && n < 40) begin
         tick();
         n++;
      end
      checks++;
      if (sb_q.size() != 0) begin
         failures++;
         $display("FAIL drain actual=%0d pending required=0 pending", sb_q.size());
         sb_q.delete();
      end
   endtask

   // Scoreboard monitor: every subkey_valid must match the oldest expectation
   // and arrive exactly one cycle after its step was sampled.
   always @(negedge clk) begin
      if (sb_q.size() != 0 && sb_q[0].due < cyc) begin
         checks++;
         failures++;
         $display("FAIL missed_pulse actual=absent required=round %0d at cycle %0d", sb_q[0].round, sb_q[0].due);
         void'(sb_q.pop_front());
      end
      if (subkey_valid === 1'b1) begin
         if (sb_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_valid actual=1 required=0 round=%0d subkey=%h", subkey_round, subkey);
         end else begin
            mon_e = sb_q.pop_front();
            $display("subkey round=%0d value=%h done=%0b cycle=%0d", subkey_round, subkey, done, cyc);
            chk("sb_subkey", 64'(subkey), 64'(mon_e.subkey));
            chk("sb_round", 64'(subkey_round), 64'(mon_e.round));
            chk("sb_done", 64'(done), 64'(mon_e.done));
            chk("sb_latency", 64'(cyc), 64'(mon_e.due));
         end
      end else if (done === 1'b1) begin
         checks++;
         failures++;
         $display("FAIL done_without_valid actual=1 required=0");
      end
   end

   initial begin
      gold[0]  = '{4'd0,  48'h1B02EFFC7072};
      gold[1]  = '{4'd1,  48'h79AED9DBC9E5};
      gold[2]  = '{4'd2,  48'h55FC8A42CF99};
      gold[3]  = '{4'd3,  48'h72ADD6DB351D};
      gold[4]  = '{4'd4,  48'h7CEC07EB53A8};
      gold[5]  = '{4'd5,  48'h63A53E507B2F};
      gold[6]  = '{4'd6,  48'hEC84B7F618BC};
      gold[7]  = '{4'd7,  48'hF78A3AC13BFB};
      gold[8]  = '{4'd8,  48'hE0DBEBEDE781};
      gold[9]  = '{4'd9,  48'hB1F347BA464F};
      gold[10] = '{4'd10, 48'h215FD3DED386};
      gold[11] = '{4'd11, 48'h7571F59467E9};
      gold[12] = '{4'd12, 48'h97C5D1FABA41};
      gold[13] = '{4'd13, 48'h5F43B7F2E73A};
      gold[14] = '{4'd14, 48'hBF918D3D3F0A};
      gold[15] = '{4'd15, 48'hCB3D8B0E17F5};

      exp_armed = 1'b0;
      exp_cnt   = 0;
      key_in    = '0;
      decrypt   = 1'b0;
      load      = 1'b0;
      step      = 1'b0;
      reset_n   = 1'b1;
      #3 reset_n = 1'b0;
      repeat (3) tick();
      chk("rst_subkey", 64'(subkey), 64'h0);
      chk("rst_valid", 64'(subkey_valid), 64'h0);
      chk("rst_round", 64'(subkey_round), 64'h0);
      chk("rst_busy", 64'(busy), 64'h0);
      chk("rst_done", 64'(done), 64'h0);
      reset_n = 1'b1;
      tick();

      // Encrypt vector, back-to-back, table-driven.
      do_load(KEY_A, 1'b0, KEY_A, 1'b1);
      chk("enc_busy_after_load", 64'(busy), 64'h1);
      for (int i = 0; i < 16; i++) begin
         step_once();
         chk($sformatf("enc_subkey_r%0d", i), 64'(subkey), 64'(gold[i].subkey));
         chk($sformatf("enc_round_r%0d", i), 64'(subkey_round), 64'(gold[i].round));
      end
      chk("enc_busy_after_done", 64'(busy), 64'h0);
      drain();

      // Decrypt vector against the software model.
      do_load(KEY_A, 1'b1, KEY_A, 1'b0);
      for (int i = 0; i < 16; i++) begin
         step_once();
         if (i == 0)  chk("dec_first", 64'(subkey), 64'h0000CB3D8B0E17F5);
         if (i == 15) chk("dec_last", 64'(subkey), 64'h00001B02EFFC7072);
      end
      chk("dec_busy_after_done", 64'(busy), 64'h0);
      drain();

      // Gapped stepping, then a 17th step that must be ignored.
      do_load(KEY_A, 1'b0, KEY_A, 1'b1);
      for (int i = 0; i < 16; i++) begin
         step_once();
         repeat ($urandom_range(0, 3)) tick();
      end
      drain();
      step_once();
      repeat (2) tick();
      chk("step17_subkey_hold", 64'(subkey), 64'h0000CB3D8B0E17F5);
      chk("step17_round_hold", 64'(subkey_round), 64'd15);
      chk("step17_busy", 64'(busy), 64'h0);

      // load and step together: load wins, schedule starts at round 0.
      key_in  = KEY_A;
      decrypt = 1'b0;
      load    = 1'b1;
      step    = 1'b1;
      arm(KEY_A, 1'b0, 1'b1);
      tick();
      load = 1'b0;
      step = 1'b0;
      repeat (2) tick();
      chk("collide_busy", 64'(busy), 64'h1);
      for (int i = 0; i < 5; i++) step_once();
      // Re-load with a new key after 5 subkeys; next must be K1 of KEY_B.
      do_load(KEY_B, 1'b0, KEY_B, 1'b0);
      for (int i = 0; i < 16; i++) step_once();
      drain();

      // Asynchronous reset in the middle of a cycle while round 7 is shown.
      do_load(KEY_A, 1'b0, KEY_A, 1'b1);
      for (int i = 0; i < 8; i++) step_once();
      #5;
      chk("pre_reset_round", 64'(subkey_round), 64'd7);
      chk("pre_reset_busy", 64'(busy), 64'h1);
      reset_n = 1'b0;
      #1;
      chk("arst_subkey", 64'(subkey), 64'h0);
      chk("arst_valid", 64'(subkey_valid), 64'h0);
      chk("arst_round", 64'(subkey_round), 64'h0);
      chk("arst_busy", 64'(busy), 64'h0);
      chk("arst_done", 64'(done), 64'h0);
      exp_armed = 1'b0;
      drain();
      tick();
      reset_n = 1'b1;
      for (int i = 0; i < 3; i++) step_once();
      tick();
      chk("post_reset_subkey", 64'(subkey), 64'h0);
      chk("post_reset_busy", 64'(busy), 64'h0);

      // Parity bits flipped and inputs changed after load: sequence unchanged.
      do_load(KEY_A ^ 64'h0101010101010101, 1'b0, KEY_A, 1'b1);
      key_in  = 64'hFFEEDDCCBBAA9988;
      decrypt = 1'b1;
      for (int i = 0; i < 16; i++) begin
         step_once();
         if (i == 3) key_in = {$urandom(), $urandom()};
      end
      chk("parity_last", 64'(subkey), 64'h0000CB3D8B0E17F5);
      drain();

      repeat (3) tick();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout actual=running required=finished");
      $fatal(1, "timeout");
   end

endmodule
